// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous PWM line.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int CW = 16
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          pwm_in,
    output logic [CW-1:0] high_count,
    output logic [CW-1:0] period_count,
    output logic          meas_valid,
    output logic          timeout,
    output logic          stuck_level,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic          w_lvl;
    logic          w_rise;
    logic          w_fall;
    logic          w_sat;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_hi_cnt;
    logic [CW-1:0] r_per_cnt;

    logic          w_cnt_start;
    logic          w_cnt_clr;
    logic          w_per_inc;
    logic          w_hi_inc;
    logic          w_latch;
    logic          w_to_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Level only moves after FILT_LEN identical samples; equal delay on both edges keeps counts exact.
    logic [FILT_LEN-1:0] r_filt;
    logic                r_filt_lvl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_filt     <= '0;
            r_filt_lvl <= 1'b0;
        end else begin
            r_filt <= {r_filt[FILT_LEN-2:0], r_sync2};
            if (&r_filt) begin
                r_filt_lvl <= 1'b1;
            end else if (~|r_filt) begin
                r_filt_lvl <= 1'b0;
            end
        end
    end

    assign w_lvl = r_filt_lvl;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_lvl;
        end
    end

    assign w_rise = w_lvl & ~r_prev;
    assign w_fall = ~w_lvl & r_prev;
    assign w_sat  = (r_per_cnt == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority: enable drop, then rise (a rise on the saturating cycle still measures), then saturation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_rise) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!enable || w_sat) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                end else if (w_sat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnt_start = 1'b0;
        w_cnt_clr   = 1'b0;
        w_per_inc   = 1'b0;
        w_hi_inc    = 1'b0;
        w_latch     = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_rise) begin
                    w_cnt_start = 1'b1;
                end else begin
                    w_cnt_clr = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!enable) begin
                    w_cnt_clr = 1'b1;
                end else if (w_sat) begin
                    w_to_set  = 1'b1;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_per_inc = 1'b1;
                    w_hi_inc  = ~w_fall;
                end
            end
            ST_LOW: begin
                if (!enable) begin
                    w_cnt_clr = 1'b1;
                end else if (w_rise) begin
                    w_latch     = 1'b1;
                    w_cnt_start = 1'b1;
                end else if (w_sat) begin
                    w_to_set  = 1'b1;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_per_inc = 1'b1;
                end
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    // The rising-edge cycle itself is the first high cycle and the first period cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
        end else if (w_cnt_start) begin
            r_hi_cnt  <= CNT_ONE;
            r_per_cnt <= CNT_ONE;
        end else if (w_cnt_clr) begin
            r_hi_cnt  <= '0;
            r_per_cnt <= '0;
        end else begin
            if (w_per_inc) begin
                r_per_cnt <= r_per_cnt + CNT_ONE;
            end
            if (w_hi_inc) begin
                r_hi_cnt <= r_hi_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_count   <= '0;
            period_count <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
            stuck_level  <= 1'b0;
        end else begin
            meas_valid <= w_latch;
            if (w_latch) begin
                high_count   <= r_hi_cnt;
                period_count <= r_per_cnt;
                timeout      <= 1'b0;
            end else if (w_to_set) begin
                timeout     <= 1'b1;
                stuck_level <= w_lvl;
            end
        end
    end

    assign dbg_state = r_state;

endmodule
